rf_write_arbiter: RTL and testbench
===================================

# rf_write_arbiter

Shares the register file's single write port among NREQ writeback requesters (execute-stage ALU result, CSR/switch-input unit, future load unit). Each cycle it grants at most one valid requester with round-robin fairness, completes a valid/ready handshake, and registers the winning address/data onto the regfile `we`/`writeaddr`/`writedata` pins one cycle later. Writes to x0 are accepted but suppressed. It sits between the pipeline writeback sources and `regfile`.

## Interface
- NREQ, 2, number of requesters (2..8)
- AW, 5, register address width
- DW, 32, write data width
- CW, 16, width of the accepted-write counter

- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- hold  input  1  when 1, no grants are issued this cycle
- req_valid  input  NREQ  bit i: requester i has a pending write
- req_addr  input  NREQ*AW  requester i destination register, bits [i*AW +: AW]
- req_data  input  NREQ*DW  requester i write data, bits [i*DW +: DW]
- req_ready  output  NREQ  one-hot or zero; bit i: requester i granted this cycle
- rf_we  output  1  regfile write enable
- rf_waddr  output  AW  regfile write address
- rf_wdata  output  DW  regfile write data
- grant_id  output  $clog2(NREQ)  index of requester whose write is on rf_* this cycle
- wr_count  output  CW  saturating count of non-x0 writes issued

## Operation
- Handshake: transfer from requester i occurs in a cycle where req_valid[i] & req_ready[i]. Requester keeps valid, addr, data stable until transfer; valid may not drop before transfer. Ready is combinational from valid, hold and pointer; at most one ready bit high.
- Arbitration: pointer `ptr` holds last granted index. Search order ptr+1, ptr+2, ... wrapping modulo NREQ; first valid requester wins. hold=1 or no valid → req_ready all zero, ptr unchanged.
- ptr updates to winning index only on a transfer.
- Work-conserving: a lone valid requester is granted every cycle it is valid (back-to-back writes allowed).
- Output stage (registered): on transfer from i, next cycle rf_waddr=addr_i, rf_wdata=data_i, grant_id=i, rf_we = (addr_i != 0). No transfer → rf_we=0 next cycle; rf_waddr/rf_wdata/grant_id hold previous values.
- x0: transfer completes (ready=1), rf_we stays 0, wr_count not incremented.
- wr_count increments by 1 with each rf_we=1 cycle's registration; saturates at 2^CW-1, never wraps.

## Timing
- Reset (async assert, any time): rf_we=0, rf_waddr=0, rf_wdata=0, grant_id=0, wr_count=0, ptr=NREQ-1 (requester 0 has first priority). req_ready=0 while rst_n=0.
- Reset mid-operation: a transfer in the cycle reset asserts is discarded; no rf_we pulse follows. Deassertion is synchronised by the system; first grant possible in the first clock edge after release.
- Latency: transfer in cycle N → rf_we/addr/data valid in cycle N+1, written into regfile at edge ending N+1.
- Throughput: one write per cycle maximum.
- hold rising in cycle N: no ready in N; rf_we=0 in N+1 (a transfer in N-1 still appears in N).
- All NREQ valid continuously: grants rotate i, i+1, ... ; each requester waits at most NREQ-1 cycles.
- Simultaneous request and ptr wrap: after granting NREQ-1, next search starts at 0.

## Test plan
- Reset release, req_valid=01, addr0=5, data0=0xDEADBEEF → ready=01 at cycle 0; cycle 1 rf_we=1, waddr=5, wdata=0xDEADBEEF, grant_id=0, wr_count=1.
- Both valid held 6 cycles (addr0=1, addr1=2) → grants 0,1,0,1,0,1; rf_waddr sequence 1,2,1,2,1,2 one cycle delayed; wr_count=6.
- Requester 1 writes x0 with data 0x1234 → ready[1]=1, next cycle rf_we=0, wr_count unchanged.
- hold=1 for 3 cycles with both valid → req_ready=00, rf_we=0 cycles 2-4; after release grant resumes at index ptr+1.
- CW=4, continuous non-x0 writes for 20 cycles → wr_count reaches 15 and stays 15.
- Assert rst_n=0 mid-cycle during a transfer → outputs zero immediately, no rf_we pulse after release, first grant goes to requester 0.

Source files
------------

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: round-robin arbiter for the single register-file write port.
// Each cycle at most one valid requester is granted through a valid/ready
// handshake. The winning address/data is registered onto the regfile pins one
// cycle later. Writes to x0 are accepted but never assert rf_we.
module rf_write_arbiter #(
    parameter int NREQ = 2,
    parameter int AW   = 5,
    parameter int DW   = 32,
    parameter int CW   = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      hold,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*AW-1:0]        req_addr,
    input  logic [NREQ*DW-1:0]        req_data,
    output logic [NREQ-1:0]           req_ready,
    output logic                      rf_we,
    output logic [AW-1:0]             rf_waddr,
    output logic [DW-1:0]             rf_wdata,
    output logic [$clog2(NREQ)-1:0]   grant_id,
    output logic [CW-1:0]             wr_count
);

    localparam int            IW       = $clog2(NREQ);
    localparam logic [IW-1:0] LAST_IDX = IW'(NREQ - 1);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

    // Per-requester views of the packed address/data buses.
    logic [AW-1:0] addr_arr [NREQ];
    logic [DW-1:0] data_arr [NREQ];

    // Arbitration state and results.
    logic [IW-1:0] ptr_reg, ptr_next;
    logic [IW-1:0] win_idx;
    logic          win_found;
    logic          grant_en;

    // Output stage registers.
    logic          we_reg,    we_next;
    logic [AW-1:0] waddr_reg, waddr_next;
    logic [DW-1:0] wdata_reg, wdata_next;
    logic [IW-1:0] gid_reg,   gid_next;
    logic [CW-1:0] cnt_reg,   cnt_next;

    // Slice the flat request buses into one entry per requester.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign addr_arr[gi] = req_addr[gi*AW +: AW];
            assign data_arr[gi] = req_data[gi*DW +: DW];
        end
    endgenerate

    // Round-robin search: start one past the last winner, wrap modulo NREQ,
    // first valid requester wins.
    always_comb begin
        logic [IW-1:0] cand;
        cand      = '0;
        win_found = 1'b0;
        win_idx   = ptr_reg;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IW'((int'(ptr_reg) + k) % NREQ);
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // A grant happens only out of reset, without hold, and with a valid winner.
    // Since ready only ever rises on a valid requester, a grant is a transfer.
    assign grant_en = rst_n & ~hold & win_found;

    // One-hot (or zero) ready, combinational from valid, hold and pointer.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
            assign req_ready[gi] = grant_en && (win_idx == IW'(gi));
        end
    endgenerate

    // Next-state for pointer, output stage and saturating write counter.
    always_comb begin
        ptr_next   = ptr_reg;
        we_next    = 1'b0;
        waddr_next = waddr_reg;
        wdata_next = wdata_reg;
        gid_next   = gid_reg;
        cnt_next   = cnt_reg;
        if (grant_en) begin
            ptr_next   = win_idx;
            waddr_next = addr_arr[win_idx];
            wdata_next = data_arr[win_idx];
            gid_next   = win_idx;
            // x0 is architecturally zero: accept the write but never enable it.
            we_next    = (addr_arr[win_idx] != '0);
        end
        if (we_next && (cnt_reg != CNT_MAX)) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    // State registers; reset makes requester 0 the first in line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg   <= LAST_IDX;
            we_reg    <= 1'b0;
            waddr_reg <= '0;
            wdata_reg <= '0;
            gid_reg   <= '0;
            cnt_reg   <= '0;
        end else begin
            ptr_reg   <= ptr_next;
            we_reg    <= we_next;
            waddr_reg <= waddr_next;
            wdata_reg <= wdata_next;
            gid_reg   <= gid_next;
            cnt_reg   <= cnt_next;
        end
    end

    assign rf_we    = we_reg;
    assign rf_waddr = waddr_reg;
    assign rf_wdata = wdata_reg;
    assign grant_id = gid_reg;
    assign wr_count = cnt_reg;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Testbench for rf_write_arbiter: table-driven vectors with hand-derived
// ready patterns, a queue of expected regfile-side results, plus hand-written
// sequences for hold, counter saturation and mid-operation reset.
module tb_rf_write_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hold;
    logic [1:0]  req_valid;
    logic [9:0]  req_addr;
    logic [63:0] req_data;

    logic [1:0]  req_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        grant_id;
    logic [15:0] wr_count;

    logic [1:0]  s_req_ready;
    logic        s_rf_we;
    logic [4:0]  s_rf_waddr;
    logic [31:0] s_rf_wdata;
    logic        s_grant_id;
    logic [3:0]  s_wr_count;

    int n_checks = 0;
    int n_fail   = 0;
    int n_cyc    = 0;

    rf_write_arbiter #(.NREQ(2), .AW(5), .DW(32), .CW(16)) dut (
        .clk(clk), .rst_n(rst_n), .hold(hold),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready), .rf_we(rf_we), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .grant_id(grant_id), .wr_count(wr_count)
    );

    // Narrow-counter instance sharing the same stimulus, for saturation.
    rf_write_arbiter #(.NREQ(2), .AW(5), .DW(32), .CW(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .hold(hold),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(s_req_ready), .rf_we(s_rf_we), .rf_waddr(s_rf_waddr),
        .rf_wdata(s_rf_wdata), .grant_id(s_grant_id), .wr_count(s_wr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  valid;
        logic        hld;
        logic [4:0]  a0;
        logic [4:0]  a1;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [1:0]  exp_ready;
    } vec_t;

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        gid;
        logic [15:0] cnt;
        logic [3:0]  cnt_sat;
    } out_t;

    out_t sb_q[$];

    // Reference model of the registered side.
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;
    logic        m_gid;
    logic [15:0] m_cnt;
    logic [3:0]  m_cnt_sat;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_waddr   = '0;
        m_wdata   = '0;
        m_gid     = 1'b0;
        m_cnt     = '0;
        m_cnt_sat = '0;
        sb_q.delete();
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_ready"},     req_ready,   2'b00);
        chk({tag, "_we"},        rf_we,       1'b0);
        chk({tag, "_waddr"},     rf_waddr,    5'd0);
        chk({tag, "_wdata"},     rf_wdata,    32'd0);
        chk({tag, "_gid"},       grant_id,    1'b0);
        chk({tag, "_cnt"},       wr_count,    16'd0);
        chk({tag, "_sat_ready"}, s_req_ready, 2'b00);
        chk({tag, "_sat_cnt"},   s_wr_count,  4'd0);
    endtask

    function automatic vec_t mk(input logic [1:0] valid, input logic hld,
                                input logic [4:0] a0, input logic [4:0] a1,
                                input logic [31:0] d0, input logic [31:0] d1,
                                input logic [1:0] er);
        vec_t v;
        v.valid = valid; v.hld = hld; v.a0 = a0; v.a1 = a1;
        v.d0 = d0; v.d1 = d1; v.exp_ready = er;
        return v;
    endfunction

    // Called just after a rising edge: drive, check ready, predict, advance one
    // clock, then pop and compare the registered result.
    task automatic run_cycle(input vec_t v);
        out_t e;
        out_t got;
        req_valid = v.valid;
        hold      = v.hld;
        req_addr  = {v.a1, v.a0};
        req_data  = {v.d1, v.d0};
        #2;
        chk("ready",     req_ready,   v.exp_ready);
        chk("sat_ready", s_req_ready, v.exp_ready);
        e.we = 1'b0;
        if (v.exp_ready[0]) begin
            m_waddr = v.a0; m_wdata = v.d0; m_gid = 1'b0; e.we = (v.a0 != 5'd0);
        end else if (v.exp_ready[1]) begin
            m_waddr = v.a1; m_wdata = v.d1; m_gid = 1'b1; e.we = (v.a1 != 5'd0);
        end
        if (e.we) begin
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            if (m_cnt_sat != 4'hF) m_cnt_sat = m_cnt_sat + 4'd1;
        end
        e.waddr = m_waddr; e.wdata = m_wdata; e.gid = m_gid;
        e.cnt = m_cnt; e.cnt_sat = m_cnt_sat;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        n_cyc++;
        got = sb_q.pop_front();
        chk("rf_we",    rf_we,      got.we);
        chk("rf_waddr", rf_waddr,   got.waddr);
        chk("rf_wdata", rf_wdata,   got.wdata);
        chk("grant_id", grant_id,   got.gid);
        chk("wr_count", wr_count,   got.cnt);
        chk("sat_we",   s_rf_we,    got.we);
        chk("sat_cnt",  s_wr_count, got.cnt_sat);
        $display("cyc %0d valid=%b hold=%b ready=%b -> we=%b waddr=%0d wdata=%h gid=%0d cnt=%0d sat=%0d",
                 n_cyc, v.valid, v.hld, req_ready, rf_we, rf_waddr, rf_wdata, grant_id, wr_count, s_wr_count);
    endtask

    vec_t tbl[19];

    initial begin
        // Directed table (NREQ=2). Pointer starts at 1 after reset.
        tbl[0]  = mk(2'b01, 1'b0, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0,        2'b01);
        tbl[1]  = mk(2'b00, 1'b0, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0,        2'b00);
        tbl[2]  = mk(2'b11, 1'b0, 5'd1, 5'd2, 32'hA0A00001, 32'hB1B10002, 2'b10);
        tbl[3]  = mk(2'b11, 1'b0, 5'd1, 5'd2, 32'hA0A00001, 32'hB1B10002, 2'b01);
        tbl[4]  = mk(2'b11, 1'b0, 5'd1, 5'd2, 32'hA0A00001, 32'hB1B10002, 2'b10);
        tbl[5]  = mk(2'b11, 1'b0, 5'd1, 5'd2, 32'hA0A00001, 32'hB1B10002, 2'b01);
        tbl[6]  = mk(2'b11, 1'b0, 5'd1, 5'd2, 32'hA0A00001, 32'hB1B10002, 2'b10);
        tbl[7]  = mk(2'b11, 1'b0, 5'd1, 5'd2, 32'hA0A00001, 32'hB1B10002, 2'b01);
        tbl[8]  = mk(2'b10, 1'b0, 5'd1, 5'd0, 32'hA0A00001, 32'h00001234, 2'b10);
        tbl[9]  = mk(2'b01, 1'b0, 5'd0, 5'd0, 32'h55555555, 32'h00001234, 2'b01);
        tbl[10] = mk(2'b11, 1'b1, 5'd3, 5'd4, 32'h33333333, 32'h44444444, 2'b00);
        tbl[11] = mk(2'b11, 1'b1, 5'd3, 5'd4, 32'h33333333, 32'h44444444, 2'b00);
        tbl[12] = mk(2'b11, 1'b1, 5'd3, 5'd4, 32'h33333333, 32'h44444444, 2'b00);
        tbl[13] = mk(2'b11, 1'b0, 5'd3, 5'd4, 32'h33333333, 32'h44444444, 2'b10);
        tbl[14] = mk(2'b11, 1'b0, 5'd3, 5'd4, 32'h33333333, 32'h44444444, 2'b01);
        tbl[15] = mk(2'b01, 1'b0, 5'd3, 5'd4, 32'h33333333, 32'h44444444, 2'b01);
        tbl[16] = mk(2'b01, 1'b0, 5'd3, 5'd4, 32'hCAFEF00D, 32'h44444444, 2'b01);
        tbl[17] = mk(2'b10, 1'b0, 5'd3, 5'd7, 32'hCAFEF00D, 32'h77777777, 2'b10);
        tbl[18] = mk(2'b00, 1'b0, 5'd3, 5'd7, 32'hCAFEF00D, 32'h77777777, 2'b00);

        // Reset with requests pending: ready must stay low.
        rst_n     = 1'b0;
        hold      = 1'b0;
        req_valid = 2'b11;
        req_addr  = {5'd2, 5'd1};
        req_data  = {32'h11111111, 32'h22222222};
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_zero_outputs("reset");
        rst_n = 1'b1;

        foreach (tbl[i]) run_cycle(tbl[i]);

        // Lone requester writing continuously: back-to-back grants, counter
        // of the narrow instance saturates at 15.
        for (int i = 0; i < 20; i++) begin
            run_cycle(mk(2'b01, 1'b0, 5'd9, 5'd0, 32'h90000000 + i, 32'h0, 2'b01));
        end
        chk("sat_stays_15", s_wr_count, 4'hF);

        // Reset asserted in the middle of a transfer cycle (pointer is 0).
        req_valid = 2'b11;
        hold      = 1'b0;
        req_addr  = {5'd6, 5'd4};
        req_data  = {32'h66666666, 32'h44440000};
        #2;
        chk("pre_rst_ready", req_ready, 2'b10);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero_outputs("async_rst");
        model_reset();
        @(posedge clk);
        #1;
        chk_zero_outputs("rst_hold");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_cycle(mk(2'b11, 1'b0, 5'd4, 5'd6, 32'h44440000, 32'h66666666, 2'b01));
        run_cycle(mk(2'b11, 1'b0, 5'd4, 5'd6, 32'h44440000, 32'h66666666, 2'b10));
        run_cycle(mk(2'b00, 1'b0, 5'd4, 5'd6, 32'h44440000, 32'h66666666, 2'b00));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
